// File: rtl/rotor_pkg.sv
// rotor_pkg: shared constants and types for the rotor/flux angle datapath.
//   N_DEF, Q_DEF : default word width and fractional bits (sign-magnitude Q12.12)
//   ITER_DEF     : default CORDIC micro-rotation count
//   ZF           : fractional bits of the CORDIC angle accumulator
//   ATAN         : atan(2^-i) scaled by 2^ZF, i = 0..15
//   PI_Z         : pi scaled by 2^ZF
//   K_INV        : inverse CORDIC gain 0.607253 as K_INV / 2^K_INV_Q
//   cordic_state_e : vectoring FSM states
package rotor_pkg;

  localparam int unsigned N_DEF    = 24;
  localparam int unsigned Q_DEF    = 12;
  localparam int unsigned ITER_DEF = 14;

  localparam int unsigned ZF   = 16;
  localparam int unsigned PI_Z = 205887;

  localparam int unsigned K_INV   = 2487;
  localparam int unsigned K_INV_Q = 12;

  localparam int unsigned ATAN [16] = '{
    51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
    256,   128,   64,    32,   16,   8,    4,    2
  };

  typedef enum logic [2:0] {
    IDLE,
    PREROT,
    ROTATE,
    FINISH,
    HOLD
  } cordic_state_e;

endpackage

// File: rtl/sm_tc_conv.sv
// sm_tc_conv: combinational sign-magnitude <-> two's-complement converter.
//   W     : word width (sign bit W-1)
//   TO_TC : 1 = sign-magnitude in, two's complement out; 0 = the reverse
//   din   : input word
//   dout  : converted word; negative zero always maps to +0
module sm_tc_conv #(
  parameter int unsigned W     = 24,
  parameter bit          TO_TC = 1'b1
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (TO_TC) begin : g_to_tc
    logic [W-2:0] mag;
    assign mag  = din[W-2:0];
    // Negating a zero magnitude yields zero, so -0 collapses to +0 here
    assign dout = din[W-1] ? (W'(0) - {1'b0, mag}) : {1'b0, mag};
  end else begin : g_to_sm
    logic [W-2:0] mag;
    assign mag  = din[W-1] ? (W-1)'(W'(0) - din) : din[W-2:0];
    // Sign is only set for a non-zero magnitude
    assign dout = {din[W-1] && (mag != '0), mag};
  end

endmodule

// File: rtl/flux_angle_cordic.sv
// flux_angle_cordic: iterative CORDIC vectoring unit, (cos, sin) -> (angle, magnitude).
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : input handshake, in_ready high only in IDLE
//   in_cos, in_sin        : x / y components, sign-magnitude Q12.12
//   out_valid/out_ready   : output handshake, result held until accepted
//   out_angle             : angle in radians, sign-magnitude Q12.12, (-pi, pi]
//   out_mag               : magnitude, sign bit always 0
//   out_sat               : magnitude was clamped on this result
// Optional feature macro FLUX_CORDIC_GAIN_COMP_EN: when defined, out_mag is
// scaled by K_INV to remove the CORDIC gain; otherwise the raw x is emitted.
module flux_angle_cordic
  import rotor_pkg::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned Q    = Q_DEF,
  parameter int unsigned ITER = ITER_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_cos,
  input  logic [N-1:0] in_sin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_angle,
  output logic [N-1:0] out_mag,
  output logic         out_sat
);

  localparam int unsigned TW  = N + 2;       // two's complement with guard bits
  localparam int unsigned GF  = 4;           // extra fractional bits in x/y
  localparam int unsigned DW  = TW + GF;
  localparam int unsigned ZW  = 20;          // covers +-(pi + 1.75) at 2^-16
  localparam int unsigned ZS  = ZF - Q;
  localparam int unsigned CW  = 4;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  cordic_state_e state;

  logic [N-1:0]          cos_r, sin_r;
  logic [N-1:0]          cos_tc, sin_tc;
  logic signed [TW-1:0]  x_in, y_in, x_abs;
  logic signed [DW-1:0]  x0, y0;
  logic signed [DW-1:0]  x_r, y_r, x_sh, y_sh;
  logic signed [ZW-1:0]  z_r;
  logic [CW-1:0]         cnt;
  logic                  xneg, ysgn, zero_r;

  logic signed [ZW-1:0]  z_unf, angle_z;
  logic [ZW-1:0]         z_abs, z_rnd;
  logic [N-1:0]          angle_tc, angle_sm;
  logic [N-2:0]          mag_c;
  logic                  sat_c;

  // Input conversion to two's complement
  sm_tc_conv #(.W(N), .TO_TC(1'b1)) u_cos_conv (.din(cos_r), .dout(cos_tc));
  sm_tc_conv #(.W(N), .TO_TC(1'b1)) u_sin_conv (.din(sin_r), .dout(sin_tc));

  // Pre-rotation: sign-extend, fold into the right half-plane, add fraction guard
  always_comb begin
    x_in  = TW'(signed'(cos_tc));
    y_in  = TW'(signed'(sin_tc));
    x_abs = x_in[TW-1] ? (TW'(0) - x_in) : x_in;
    x0    = {x_abs, {GF{1'b0}}};
    y0    = {y_in, {GF{1'b0}}};
  end

  assign x_sh = x_r >>> cnt;
  assign y_sh = y_r >>> cnt;

  // Angle unfold, round half away from zero to Q bits, zero-input override
  always_comb begin
    z_unf = z_r;
    if (xneg) begin
      if (ysgn) z_unf = ZW'(0) - ZW'(PI_Z) - z_r;
      else      z_unf = ZW'(PI_Z) - z_r;
    end
    z_abs   = z_unf[ZW-1] ? (ZW'(0) - z_unf) : z_unf;
    z_rnd   = (z_abs + ZW'(1 << (ZS - 1))) >> ZS;
    angle_z = z_unf[ZW-1] ? signed'(ZW'(0) - z_rnd) : signed'(z_rnd);
    if (zero_r) angle_z = '0;
  end

  assign angle_tc = N'(angle_z);

  sm_tc_conv #(.W(N), .TO_TC(1'b0)) u_ang_conv (.din(angle_tc), .dout(angle_sm));

  // Magnitude with optional gain compensation, rounded and saturated
`ifdef FLUX_CORDIC_GAIN_COMP_EN
  localparam int unsigned MW = DW + K_INV_Q;
  logic [MW-1:0] mag_prod, mag_full;
  assign mag_prod = MW'(unsigned'(x_r)) * MW'(K_INV);
  assign mag_full = (mag_prod + (MW'(1) << (K_INV_Q + GF - 1))) >> (K_INV_Q + GF);
  assign sat_c    = (mag_full[MW-1:N-1] != '0);
`else
  logic [DW-1:0] mag_full;
  assign mag_full = (unsigned'(x_r) + (DW'(1) << (GF - 1))) >> GF;
  assign sat_c    = (mag_full[DW-1:N-1] != '0);
`endif
  assign mag_c = sat_c ? {(N-1){1'b1}} : mag_full[N-2:0];

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_angle <= '0;
      out_mag   <= '0;
      out_sat   <= 1'b0;
      cos_r     <= '0;
      sin_r     <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      cnt       <= '0;
      xneg      <= 1'b0;
      ysgn      <= 1'b0;
      zero_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cos_r    <= in_cos;
            sin_r    <= in_sin;
            in_ready <= 1'b0;
            state    <= PREROT;
          end
        end
        PREROT: begin
          x_r    <= x0;
          y_r    <= y0;
          z_r    <= '0;
          cnt    <= '0;
          xneg   <= x_in[TW-1];
          ysgn   <= y_in[TW-1];
          zero_r <= (x_in == '0) && (y_in == '0);
          state  <= ROTATE;
        end
        ROTATE: begin
          // Drive y toward zero; z accumulates the rotated angle
          if (!y_r[DW-1]) begin
            x_r <= x_r + y_sh;
            y_r <= y_r - x_sh;
            z_r <= z_r + ZW'(ATAN[cnt]);
          end else begin
            x_r <= x_r - y_sh;
            y_r <= y_r + x_sh;
            z_r <= z_r - ZW'(ATAN[cnt]);
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FINISH;
        end
        FINISH: begin
          out_angle <= angle_sm;
          out_mag   <= {1'b0, mag_c};
          out_sat   <= sat_c;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
